// File: rtl/txn_pkg.sv
`default_nettype none
//-----------------------------------------------------------------------------
//  Module      : txn_pkg
//  Description : Shared types and default constants for the txn_issue burst
//                initiator and its helpers.
//                  txn_state_t        - issue FSM state encoding
//                  c_data_width       - default payload width
//                  c_len_width        - default burst-length width
//                  c_timeout_cycles   - default stall limit
//  Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
package txn_pkg;

   typedef enum logic [0:0] {
      TXN_IDLE  = 1'b0,
      TXN_ISSUE = 1'b1
   } txn_state_t;

   localparam int c_data_width     = 16;
   localparam int c_len_width      = 8;
   localparam int c_timeout_cycles = 256;

endpackage : txn_pkg
`default_nettype wire

// File: rtl/txn_issue_if.sv
`default_nettype none
//-----------------------------------------------------------------------------
//  Module      : txn_issue_if
//  Description : Valid/ready beat channel between a burst initiator and its
//                consumer.
//                  out_valid  master->slave  beat offered
//                  out_ready  slave->master  beat accepted
//                  out_data   master->slave  beat payload (DATA_WIDTH)
//                Modports: master (initiator), slave (consumer).
//  Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
interface txn_issue_if
   import txn_pkg::*;
#(
   parameter int DATA_WIDTH = c_data_width
);

   logic                  out_valid;
   logic                  out_ready;
   logic [DATA_WIDTH-1:0] out_data;

   modport master (
      output out_valid,
      output out_data,
      input  out_ready
   );

   modport slave (
      input  out_valid,
      input  out_data,
      output out_ready
   );

endinterface : txn_issue_if
`default_nettype wire

// File: rtl/txn_stall_timer.sv
`default_nettype none
//-----------------------------------------------------------------------------
//  Module      : txn_stall_timer
//  Description : Saturating count of consecutive stalled cycles. hit is
//                asserted combinationally during the stalled cycle that
//                completes TIMEOUT_CYCLES consecutive stalls, so the caller
//                can abort on that same clock edge.
//                  clk      input   clock
//                  reset_n  input   asynchronous active-low reset
//                  stall    input   beat offered but not accepted this cycle
//                  hit      output  stall limit reached this cycle
//  Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
module txn_stall_timer #(
   parameter int TIMEOUT_CYCLES = 256
) (
   input  wire logic clk,
   input  wire logic reset_n,
   input  wire logic stall,
   output logic      hit
);

   localparam int c_cnt_w = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [c_cnt_w-1:0] c_limit_m1 = c_cnt_w'(TIMEOUT_CYCLES - 1);

   logic [c_cnt_w-1:0] r_cnt;

   // r_cnt holds the number of stalls already seen in the current run, so the
   // cycle in which it equals TIMEOUT_CYCLES-1 and still stalls is the last one.
   assign hit = stall && (r_cnt >= c_limit_m1);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (!stall) begin
         r_cnt <= '0;
      end else if (r_cnt < c_limit_m1) begin
         r_cnt <= r_cnt + c_cnt_w'(1);
      end
   end

endmodule : txn_stall_timer
`default_nettype wire

// File: rtl/txn_issue.sv
`default_nettype none
//-----------------------------------------------------------------------------
//  Module      : txn_issue
//  Description : Command-driven burst initiator. An accepted start issues len
//                beats of payload base+index on a valid/ready channel, holding
//                valid/data until each beat is taken, and raises a sticky
//                done after the final handshake.
//                  clk      input   clock
//                  reset_n  input   asynchronous active-low reset
//                  start    input   command strobe (ignored while busy)
//                  base     input   first beat payload
//                  len      input   beat count (0 = complete immediately)
//                  clear    input   clears sticky done / err
//                  busy     output  burst in progress
//                  out_if   master  valid/ready beat channel
//                  done     output  sticky burst-complete flag
//                  err      output  sticky timeout flag (timeout build only)
//                Build option: define TXN_ISSUE_TIMEOUT_EN to abort a burst
//                after TIMEOUT_CYCLES consecutive stalled cycles.
//  Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
module txn_issue
   import txn_pkg::*;
#(
   parameter int DATA_WIDTH     = c_data_width,
   parameter int LEN_WIDTH      = c_len_width,
   parameter int TIMEOUT_CYCLES = c_timeout_cycles
) (
   input  wire logic                  clk,
   input  wire logic                  reset_n,
   input  wire logic                  start,
   input  wire logic [DATA_WIDTH-1:0] base,
   input  wire logic [LEN_WIDTH-1:0]  len,
   input  wire logic                  clear,
   output logic                       busy,
   txn_issue_if.master                out_if,
`ifdef TXN_ISSUE_TIMEOUT_EN
   output logic                       err,
`endif
   output logic                       done
);

   txn_state_t            r_state;
   txn_state_t            w_state_nxt;
   logic [DATA_WIDTH-1:0] r_data;
   logic [LEN_WIDTH-1:0]  r_idx;
   logic [LEN_WIDTH-1:0]  r_len;
   logic                  r_done;

   logic w_valid;
   logic w_hs;
   logic w_last;
   logic w_accept;
   logic w_len_zero;
   logic w_abort;

   assign w_len_zero = (len == '0);
   assign w_accept   = (r_state == TXN_IDLE) && start;
   assign w_hs       = w_valid && out_if.out_ready;
   assign w_last     = w_hs && (r_idx == (r_len - LEN_WIDTH'(1)));

`ifdef TXN_ISSUE_TIMEOUT_EN
   logic r_err;

   // hit only fires while stalled, so it can never coincide with a handshake.
   txn_stall_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_stall_timer (
      .clk     (clk),
      .reset_n (reset_n),
      .stall   (w_valid && !out_if.out_ready),
      .hit     (w_abort)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_err <= 1'b0;
      end else if (w_abort) begin
         r_err <= 1'b1;
      end else if (w_accept || clear) begin
         r_err <= 1'b0;
      end
   end

   assign err = r_err;
`else
   assign w_abort = 1'b0;
`endif

   //--------------------------------------------------------------------------
   // FSM: next state and state-decoded outputs
   //--------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_valid     = 1'b0;
      busy        = 1'b0;
      case (r_state)
         TXN_IDLE: begin
            if (start && !w_len_zero) begin
               w_state_nxt = TXN_ISSUE;
            end
         end
         TXN_ISSUE: begin
            w_valid = 1'b1;
            busy    = 1'b1;
            if (w_last || w_abort) begin
               w_state_nxt = TXN_IDLE;
            end
         end
         default: begin
            w_state_nxt = TXN_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= TXN_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   //--------------------------------------------------------------------------
   // Datapath: payload register advances with each handshake so it stays
   // stable while the consumer stalls; wrap-around is the natural modulo add.
   //--------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_data <= '0;
         r_idx  <= '0;
         r_len  <= '0;
      end else if (w_accept && !w_len_zero) begin
         r_data <= base;
         r_idx  <= '0;
         r_len  <= len;
      end else if (w_hs) begin
         r_data <= r_data + DATA_WIDTH'(1);
         r_idx  <= r_idx + LEN_WIDTH'(1);
      end
   end

   // Set sources take priority over clear; an accepted non-empty start also
   // clears, which is what gives start precedence over a same-cycle clear.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_done <= 1'b0;
      end else if (w_last || (w_accept && w_len_zero)) begin
         r_done <= 1'b1;
      end else if (w_accept || clear) begin
         r_done <= 1'b0;
      end
   end

   assign done             = r_done;
   assign out_if.out_valid = w_valid;
   assign out_if.out_data  = r_data;

endmodule : txn_issue
`default_nettype wire

// File: tb/tb_txn_issue.sv
`default_nettype none
//-----------------------------------------------------------------------------
//  Module      : tb_txn_issue
//  Description : Directed self-checking bench for txn_issue: back-to-back
//                burst, stalled burst, payload wrap, empty burst, mid-burst
//                clear/start/async reset, and (timeout build) stall abort.
//  Revision    : 1.0 - initial release
//-----------------------------------------------------------------------------
module tb_txn_issue;

   localparam int DW = 16;
   localparam int LW = 8;
   localparam int TO = 8;

   logic          clk;
   logic          reset_n;
   logic          start;
   logic [DW-1:0] base;
   logic [LW-1:0] len;
   logic          clear;
   logic          busy;
   logic          done;
`ifdef TXN_ISSUE_TIMEOUT_EN
   logic          err;
`endif

   int n_asserts;
   int n_fail;

   txn_issue_if #(.DATA_WIDTH(DW)) bus ();

   txn_issue #(
      .DATA_WIDTH     (DW),
      .LEN_WIDTH      (LW),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start),
      .base    (base),
      .len     (len),
      .clear   (clear),
      .busy    (busy),
      .out_if  (bus.master),
`ifdef TXN_ISSUE_TIMEOUT_EN
      .err     (err),
`endif
      .done    (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   logic [6:0] ready_pat;
   int         hs;

   initial begin
      n_asserts     = 0;
      n_fail        = 0;
      reset_n       = 1'b0;
      start         = 1'b0;
      base          = '0;
      len           = '0;
      clear         = 1'b0;
      bus.out_ready = 1'b1;

      // Reset state
      tick();
      tick();
      chk("rst_busy",  32'(busy), 32'h0);
      chk("rst_valid", 32'(bus.out_valid), 32'h0);
      chk("rst_data",  32'(bus.out_data), 32'h0);
      chk("rst_done",  32'(done), 32'h0);
      reset_n = 1'b1;
      tick();

      // Back-to-back burst: base 0x0010, len 4
      start = 1'b1; base = 16'h0010; len = 8'd4;
      tick();
      start = 1'b0;
      chk("b2b_busy0", 32'(busy), 32'h1);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("b2b_valid%0d", i), 32'(bus.out_valid), 32'h1);
         chk($sformatf("b2b_data%0d", i), 32'(bus.out_data), 32'h0010 + i);
         tick();
      end
      chk("b2b_done",  32'(done), 32'h1);
      chk("b2b_busy",  32'(busy), 32'h0);
      chk("b2b_valid", 32'(bus.out_valid), 32'h0);

      // Stalled burst: ready pattern 1,0,0,1,0,1,1 (first element first)
      ready_pat = 7'b1101001;
      hs = 0;
      start = 1'b1; base = 16'h0010; len = 8'd4;
      tick();
      start = 1'b0;
      chk("stl_done_clr", 32'(done), 32'h0);
      for (int i = 0; i < 7; i++) begin
         bus.out_ready = ready_pat[i];
         chk($sformatf("stl_valid%0d", i), 32'(bus.out_valid), 32'h1);
         chk($sformatf("stl_data%0d", i), 32'(bus.out_data), 32'h0010 + hs);
         if (ready_pat[i]) hs++;
         tick();
      end
      chk("stl_hs_cnt", 32'(hs), 32'd4);
      chk("stl_done",   32'(done), 32'h1);
      chk("stl_valid",  32'(bus.out_valid), 32'h0);

      // Payload wrap: base 0xFFFE, len 3
      bus.out_ready = 1'b1;
      start = 1'b1; base = 16'hFFFE; len = 8'd3;
      tick();
      start = 1'b0;
      chk("wrap_d0", 32'(bus.out_data), 32'hFFFE);
      tick();
      chk("wrap_d1", 32'(bus.out_data), 32'hFFFF);
      tick();
      chk("wrap_d2", 32'(bus.out_data), 32'h0000);
      chk("wrap_v2", 32'(bus.out_valid), 32'h1);
      tick();
      chk("wrap_done", 32'(done), 32'h1);
      chk("wrap_valid", 32'(bus.out_valid), 32'h0);

      // clear, then empty burst
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("clr_done", 32'(done), 32'h0);
      start = 1'b1; base = 16'h1234; len = 8'd0;
      tick();
      start = 1'b0;
      chk("len0_done",  32'(done), 32'h1);
      chk("len0_valid", 32'(bus.out_valid), 32'h0);
      chk("len0_busy",  32'(busy), 32'h0);
      tick();
      chk("len0_valid2", 32'(bus.out_valid), 32'h0);

      // Mid-burst: start+clear together, clear/start while busy, async reset
      bus.out_ready = 1'b0;
      start = 1'b1; clear = 1'b1; base = 16'h0100; len = 8'd5;
      tick();
      chk("mid_done_clr", 32'(done), 32'h0);
      chk("mid_d0",       32'(bus.out_data), 32'h0100);
      base = 16'h5000; len = 8'd2;
      tick();
      start = 1'b0; clear = 1'b0;
      chk("mid_ign_data",  32'(bus.out_data), 32'h0100);
      chk("mid_ign_busy",  32'(busy), 32'h1);
      chk("mid_ign_valid", 32'(bus.out_valid), 32'h1);
      bus.out_ready = 1'b1;
      tick();
      chk("mid_d1", 32'(bus.out_data), 32'h0101);
      tick();
      chk("mid_d2", 32'(bus.out_data), 32'h0102);
      #2;
      reset_n = 1'b0;
      #1;
      chk("arst_valid", 32'(bus.out_valid), 32'h0);
      chk("arst_busy",  32'(busy), 32'h0);
      chk("arst_done",  32'(done), 32'h0);
      chk("arst_data",  32'(bus.out_data), 32'h0);
      #1;
      reset_n = 1'b1;
      tick();
      chk("post_rst_valid", 32'(bus.out_valid), 32'h0);

`ifdef TXN_ISSUE_TIMEOUT_EN
      // Stall timeout: ready held low for a whole burst
      bus.out_ready = 1'b0;
      start = 1'b1; base = 16'h0020; len = 8'd2;
      tick();
      start = 1'b0;
      for (int i = 0; i < TO; i++) begin
         chk($sformatf("to_valid%0d", i), 32'(bus.out_valid), 32'h1);
         chk($sformatf("to_err%0d", i),   32'(err), 32'h0);
         tick();
      end
      chk("to_valid", 32'(bus.out_valid), 32'h0);
      chk("to_busy",  32'(busy), 32'h0);
      chk("to_err",   32'(err), 32'h1);
      chk("to_done",  32'(done), 32'h0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      chk("to_err_clr", 32'(err), 32'h0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule : tb_txn_issue
`default_nettype wire
